// File: rtl/acc_proc_pkg.sv
// Shared encodings for the accumulator processor: FSM states, opcodes and a
// clog2 helper used for counter sizing.
package acc_proc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EXEC = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SHL  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LI   = 4'h9;
  localparam logic [3:0] OP_LD   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hE;
  localparam logic [3:0] OP_BNEZ = 4'hF;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/acc_proc_loader.sv
// Serial frame receiver: {address, payload} MSB first under cs_i_n/cs_d_n.
// Emits a write strobe on the last bit and an error strobe on framing faults.
module acc_proc_loader
  import acc_proc_pkg::*;
#(
  parameter int OPND_W = 4,
  parameter int DATA_W = 8,
  parameter int INST_W = OPND_W + 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              idle,
  input  logic              loading,
  input  logic              cs_i_n,
  input  logic              cs_d_n,
  input  logic              sdi,
  output logic              start,
  output logic              wr_imem,
  output logic              wr_dmem,
  output logic [OPND_W-1:0] wr_addr,
  output logic [INST_W-1:0] imem_data,
  output logic [DATA_W-1:0] dmem_data,
  output logic              err
);

  localparam int I_LEN = OPND_W + INST_W;
  localparam int D_LEN = OPND_W + DATA_W;
  localparam int F_W   = (I_LEN > D_LEN) ? I_LEN : D_LEN;
  localparam int CNT_W = clog2(F_W + 1);

  logic [F_W-1:0]   sr;
  logic [F_W-1:0]   nxt;
  logic [CNT_W-1:0] cnt;
  logic             sel_i;
  logic             abort;
  logic             last;

  assign nxt   = {sr[F_W-2:0], sdi};
  assign start = idle && (cs_i_n ^ cs_d_n);
  // Frame dies if its own select lifts or the other one drops mid-frame.
  assign abort = loading && (sel_i ? (cs_i_n || !cs_d_n) : (cs_d_n || !cs_i_n));
  assign last  = loading && !abort &&
                 (cnt == (sel_i ? CNT_W'(I_LEN - 1) : CNT_W'(D_LEN - 1)));
  assign err   = (idle && !cs_i_n && !cs_d_n) || abort;

  assign wr_imem   = last && sel_i;
  assign wr_dmem   = last && !sel_i;
  assign wr_addr   = sel_i ? nxt[I_LEN-1 -: OPND_W] : nxt[D_LEN-1 -: OPND_W];
  assign imem_data = nxt[INST_W-1:0];
  assign dmem_data = nxt[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr    <= '0;
      cnt   <= '0;
      sel_i <= 1'b0;
    end else if (start) begin
      sr    <= F_W'(sdi);
      cnt   <= CNT_W'(1);
      sel_i <= !cs_i_n;
    end else if (loading) begin
      if (abort || last) begin
        sr  <= '0;
        cnt <= '0;
      end else begin
        sr  <= nxt;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/acc_proc_core.sv
// Accumulator processor: IDLE/LOAD/EXEC/HALT FSM, datapath and register-file
// memories. Optional macro SINGLE_STEP_EN adds a step input gating execution.
module acc_proc_core
  import acc_proc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OPND_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              cs_i_n,
  input  logic              cs_d_n,
  input  logic              sdi,
`ifdef SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic [OPND_W-1:0] pc_o,
  output logic [DATA_W-1:0] acc_o,
  output logic [1:0]        state_o,
  output logic              halted_o,
  output logic              load_done_o,
  output logic              frame_err_o
);

  localparam int INST_W = OPND_W + 4;
  localparam int DEPTH  = 1 << OPND_W;

  state_t             state;
  logic [OPND_W-1:0]  pc;
  logic [DATA_W-1:0]  acc;
  logic [INST_W-1:0]  imem [DEPTH];
  logic [DATA_W-1:0]  dmem [DEPTH];

  logic               ld_start, ld_wr_imem, ld_wr_dmem, ld_err;
  logic [OPND_W-1:0]  ld_addr;
  logic [INST_W-1:0]  ld_idata;
  logic [DATA_W-1:0]  ld_ddata;

  logic [INST_W-1:0]        inst;
  logic [3:0]               op;
  logic [OPND_W-1:0]        opnd;
  logic signed [OPND_W-1:0] opnd_s;
  logic [DATA_W-1:0]        sext, dval, acc_nx;
  logic [OPND_W-1:0]        pc_nx;
  logic                     taken, halt_nx, go, commit;

  acc_proc_loader #(.OPND_W(OPND_W), .DATA_W(DATA_W), .INST_W(INST_W)) u_loader (
    .clk       (clk),
    .rst_n     (rst_n),
    .idle      (state == ST_IDLE && !run),
    .loading   (state == ST_LOAD),
    .cs_i_n    (cs_i_n),
    .cs_d_n    (cs_d_n),
    .sdi       (sdi),
    .start     (ld_start),
    .wr_imem   (ld_wr_imem),
    .wr_dmem   (ld_wr_dmem),
    .wr_addr   (ld_addr),
    .imem_data (ld_idata),
    .dmem_data (ld_ddata),
    .err       (ld_err)
  );

`ifdef SINGLE_STEP_EN
  logic step_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= 1'b0;
    else        step_q <= step;
  end
  assign go = step && !step_q;
`else
  assign go = 1'b1;
`endif

  assign inst   = imem[pc];
  assign op     = inst[3:0];
  assign opnd   = inst[INST_W-1:4];
  assign opnd_s = opnd;
  assign sext   = DATA_W'(opnd_s);
  assign dval   = dmem[opnd];
  assign commit = (state == ST_EXEC) && run && go;

  always_comb begin
    acc_nx = acc;
    case (op)
      OP_ADD:  acc_nx = acc + dval;
      OP_SUB:  acc_nx = acc - dval;
      OP_AND:  acc_nx = acc & dval;
      OP_OR:   acc_nx = acc | dval;
      OP_XOR:  acc_nx = acc ^ dval;
      OP_SHL:  acc_nx = acc << 1;
      OP_SHR:  acc_nx = acc >> 1;
      OP_ADDI: acc_nx = acc + sext;
      OP_LI:   acc_nx = sext;
      OP_LD:   acc_nx = dval;
      default: acc_nx = acc;
    endcase
  end

  // Last slot halts unless it branches away; pc freezes on any halt.
  always_comb begin
    taken   = (op == OP_BNEZ) && (acc != '0);
    halt_nx = (op == OP_HALT) || ((pc == {OPND_W{1'b1}}) && !taken);
    pc_nx   = pc + OPND_W'(1);
    if (taken)   pc_nx = opnd;
    if (halt_nx) pc_nx = pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc          <= '0;
      acc         <= '0;
      load_done_o <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      load_done_o <= ld_wr_imem || ld_wr_dmem;
      frame_err_o <= ld_err;
      case (state)
        ST_IDLE: begin
          if (run) begin
            state <= ST_EXEC;
            pc    <= '0;
            acc   <= '0;
          end else if (ld_start) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: if (ld_wr_imem || ld_wr_dmem || ld_err) state <= ST_IDLE;
        ST_EXEC: begin
          if (!run) begin
            state <= ST_IDLE;
          end else if (go) begin
            acc <= acc_nx;
            pc  <= pc_nx;
            if (halt_nx) state <= ST_HALT;
          end
        end
        ST_HALT: if (!run) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        imem[i] <= '0;
        dmem[i] <= '0;
      end
    end else begin
      if (ld_wr_imem) imem[ld_addr] <= ld_idata;
      if (ld_wr_dmem)                    dmem[ld_addr] <= ld_ddata;
      else if (commit && op == OP_ST)    dmem[opnd]    <= acc;
    end
  end

  assign pc_o     = pc;
  assign acc_o    = acc;
  assign state_o  = state;
  assign halted_o = (state == ST_HALT);

endmodule

// File: tb/tb_acc_proc_core.sv
// Directed bench for acc_proc_core (DATA_W=8, OPND_W=4): loader framing,
// program execution, halt/restart and, with SINGLE_STEP_EN, stepping.
module tb_acc_proc_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       cs_i_n = 1'b1;
  logic       cs_d_n = 1'b1;
  logic       sdi = 1'b0;
  logic [3:0] pc_o;
  logic [7:0] acc_o;
  logic [1:0] state_o;
  logic       halted_o, load_done_o, frame_err_o;
`ifdef SINGLE_STEP_EN
  logic       step = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  acc_proc_core #(.DATA_W(8), .OPND_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .cs_i_n      (cs_i_n),
    .cs_d_n      (cs_d_n),
    .sdi         (sdi),
`ifdef SINGLE_STEP_EN
    .step        (step),
`endif
    .pc_o        (pc_o),
    .acc_o       (acc_o),
    .state_o     (state_o),
    .halted_o    (halted_o),
    .load_done_o (load_done_o),
    .frame_err_o (frame_err_o)
  );

  always @(negedge clk) begin
    done_cnt += int'(load_done_o);
    err_cnt  += int'(frame_err_o);
  end

  task automatic send_frame(input bit to_imem, input logic [11:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      if (to_imem) cs_i_n = 1'b0; else cs_d_n = 1'b0;
      sdi = frame[11-i];
    end
    @(negedge clk);
    cs_i_n = 1'b1;
    cs_d_n = 1'b1;
    sdi    = 1'b0;
  endtask

  task automatic load_i(input logic [3:0] a, input logic [7:0] w);
    send_frame(1'b1, {a, w}, 12);
  endtask

  task automatic load_d(input logic [3:0] a, input logic [7:0] w);
    send_frame(1'b0, {a, w}, 12);
  endtask

  task automatic wait_halt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (halted_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    settle();
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    total++; if (pc_o !== 4'd0 || acc_o !== 8'd0) begin bad++; $display("FAIL reset_pc_acc got=%0h/%0h exp=0/0", pc_o, acc_o); end
    total++; if ({halted_o, load_done_o, frame_err_o} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {halted_o, load_done_o, frame_err_o}); end
  endtask

  task automatic test_reset_mid_load();
    int d0;
    bit ok;
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cs_i_n = 1'b0;
      sdi    = 1'b1;
    end
    @(negedge clk);
    total++; if (state_o !== 2'd1) begin bad++; $display("FAIL midload_in_load got=%0d exp=1", state_o); end
    rst_n  = 1'b0;
    cs_i_n = 1'b1;
    sdi    = 1'b0;
    #1;
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL midload_reset_state got=%0d exp=0", state_o); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++; if (done_cnt !== d0) begin bad++; $display("FAIL midload_no_done got=%0d exp=%0d", done_cnt - d0, 0); end
    // Empty memories execute ADD D[0] (=0) sixteen times and halt at the end.
    run = 1'b1;
    wait_halt(ok);
    total++; if (!ok) begin bad++; $display("FAIL midload_halt_timeout got=0 exp=1"); end
    total++; if (pc_o !== 4'hF || acc_o !== 8'h00) begin bad++; $display("FAIL midload_mem_zero got=%0h/%0h exp=f/00", pc_o, acc_o); end
    run = 1'b0;
    settle();
  endtask

  task automatic test_loop();
    int d0;
    bit ok;
    d0 = done_cnt;
    load_i(4'd0, 8'h39);
    load_i(4'd1, 8'h11);
    load_i(4'd2, 8'h1F);
    load_i(4'd3, 8'h0E);
    load_d(4'd1, 8'h01);
    settle();
    total++; if (done_cnt - d0 !== 5) begin bad++; $display("FAIL loop_load_done got=%0d exp=5", done_cnt - d0); end
    run = 1'b1;
    @(negedge clk);
    total++; if (state_o !== 2'd2 || pc_o !== 4'd0) begin bad++; $display("FAIL loop_enter_exec got=%0d/%0h exp=2/0", state_o, pc_o); end
    @(negedge clk);
    total++; if (acc_o !== 8'd3) begin bad++; $display("FAIL loop_li got=%0h exp=3", acc_o); end
    @(negedge clk);
    total++; if (acc_o !== 8'd2) begin bad++; $display("FAIL loop_sub got=%0h exp=2", acc_o); end
    wait_halt(ok);
    total++; if (!ok) begin bad++; $display("FAIL loop_halt_timeout got=0 exp=1"); end
    total++; if (pc_o !== 4'd3 || acc_o !== 8'd0) begin bad++; $display("FAIL loop_final got=%0h/%0h exp=3/00", pc_o, acc_o); end
    run = 1'b0;
    settle();
    total++; if (state_o !== 2'd0 || pc_o !== 4'd3) begin bad++; $display("FAIL loop_idle_keep got=%0d/%0h exp=0/3", state_o, pc_o); end
  endtask

  task automatic test_both_selects();
    int e0;
    e0 = err_cnt;
    @(negedge clk);
    cs_i_n = 1'b0;
    cs_d_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL both_stay_idle got=%0d exp=0", state_o); end
    @(negedge clk);
    cs_i_n = 1'b1;
    cs_d_n = 1'b1;
    settle();
    total++; if (err_cnt - e0 !== 3) begin bad++; $display("FAIL both_err_pulses got=%0d exp=3", err_cnt - e0); end
  endtask

  task automatic test_abort();
    int e0, d0;
    bit ok;
    e0 = err_cnt;
    d0 = done_cnt;
    send_frame(1'b0, {4'd1, 8'hAA}, 7);
    settle();
    total++; if (err_cnt - e0 !== 1 || done_cnt !== d0) begin bad++; $display("FAIL abort_pulses got err=%0d done=%0d exp err=1 done=0", err_cnt - e0, done_cnt - d0); end
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL abort_idle got=%0d exp=0", state_o); end
    // D[1] still 1, so the countdown loop must terminate exactly as before.
    run = 1'b1;
    wait_halt(ok);
    total++; if (!ok || pc_o !== 4'd3 || acc_o !== 8'd0) begin bad++; $display("FAIL abort_dmem_kept got=%0b/%0h/%0h exp=1/3/00", ok, pc_o, acc_o); end
    run = 1'b0;
    settle();
  endtask

  task automatic test_st_ld();
    bit ok;
    load_i(4'd0, 8'hE9);
    load_i(4'd1, 8'h57);
    load_i(4'd2, 8'h18);
    load_i(4'd3, 8'h5A);
    load_i(4'd4, 8'h0E);
    run = 1'b1;
    wait_halt(ok);
    total++; if (!ok) begin bad++; $display("FAIL stld_halt_timeout got=0 exp=1"); end
    total++; if (acc_o !== 8'hFE || pc_o !== 4'd4) begin bad++; $display("FAIL stld_result got=%0h/%0h exp=fe/4", acc_o, pc_o); end
    repeat (3) @(negedge clk);
    total++; if (acc_o !== 8'hFE || state_o !== 2'd3) begin bad++; $display("FAIL stld_halt_frozen got=%0h/%0d exp=fe/3", acc_o, state_o); end
    run = 1'b0;
    settle();
    total++; if (state_o !== 2'd0 || acc_o !== 8'hFE || pc_o !== 4'd4) begin bad++; $display("FAIL stld_idle_keep got=%0d/%0h/%0h exp=0/fe/4", state_o, acc_o, pc_o); end
  endtask

  task automatic test_alu();
    bit ok;
    logic [7:0] prog [8];
    prog = '{8'h2A, 8'h05, 8'h24, 8'h23, 8'h06, 8'h20, 8'h22, 8'h0E};
    load_d(4'd2, 8'h0F);
    for (int i = 0; i < 8; i++) load_i(4'(i), prog[i]);
    run = 1'b1;
    wait_halt(ok);
    total++; if (!ok || acc_o !== 8'h0E || pc_o !== 4'd7) begin bad++; $display("FAIL alu_result got=%0b/%0h/%0h exp=1/0e/7", ok, acc_o, pc_o); end
    run = 1'b0;
    settle();
  endtask

  task automatic test_nop_end();
    bit ok;
    logic [7:0] nops [3];
    nops = '{8'h0B, 8'h1C, 8'h2D};
    for (int i = 0; i < 16; i++) load_i(4'(i), nops[i % 3]);
    run = 1'b1;
    @(negedge clk);
    total++; if (pc_o !== 4'd0 || acc_o !== 8'd0) begin bad++; $display("FAIL nop_start_clear got=%0h/%0h exp=0/00", pc_o, acc_o); end
    wait_halt(ok);
    total++; if (!ok || pc_o !== 4'hF) begin bad++; $display("FAIL nop_halt_end got=%0b/%0h exp=1/f", ok, pc_o); end
    run = 1'b0;
    settle();
    total++; if (state_o !== 2'd0 || pc_o !== 4'hF) begin bad++; $display("FAIL nop_idle_keep got=%0d/%0h exp=0/f", state_o, pc_o); end
    run = 1'b1;
    @(negedge clk);
    total++; if (state_o !== 2'd2 || pc_o !== 4'd0) begin bad++; $display("FAIL nop_restart got=%0d/%0h exp=2/0", state_o, pc_o); end
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    total++; if (state_o !== 2'd0 || pc_o !== 4'd1) begin bad++; $display("FAIL nop_run_drop got=%0d/%0h exp=0/1", state_o, pc_o); end
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_step();
    for (int i = 0; i < 16; i++) load_i(4'(i), 8'h0B);
    run = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (state_o !== 2'd2 || pc_o !== 4'd0) begin bad++; $display("FAIL step_hold got=%0d/%0h exp=2/0", state_o, pc_o); end
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      @(negedge clk);
    end
    total++; if (pc_o !== 4'd3) begin bad++; $display("FAIL step_three got=%0h exp=3", pc_o); end
    run = 1'b0;
    settle();
  endtask
`endif

  initial begin
    test_reset();
`ifdef SINGLE_STEP_EN
    test_step();
`else
    test_reset_mid_load();
    test_loop();
    test_both_selects();
    test_abort();
    test_st_ld();
    test_alu();
    test_nop_end();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acc_proc_core.md
Name: acc_proc_core

Overview:
Parametrised successor to the tiny accumulator processor. One-cycle-per-instruction accumulator machine with on-chip instruction/data register files, loaded over a serial frame port and then run.
- Adds a real loader FSM (bit counter, framing, abort detection), an explicit HALT state, a wider ISA and parametrised widths and depths.
- Sits directly under the tt_um top; the top maps ports to ui/uo/uio pins.

Parameters:
DATA_W, 8, accumulator/data-memory word width (4..16)
OPND_W, 4, operand field width; IMEM depth = DMEM depth = 2**OPND_W
INST_W, OPND_W+4, derived localparam: {operand, opcode[3:0]}

Ports:
clk  in  1  system clock; also serial-port bit clock
rst_n  in  1  asynchronous active-low reset
run  in  1  high = execute program; low = stop/return to IDLE
cs_i_n  in  1  active-low select, instruction-memory load frame
cs_d_n  in  1  active-low select, data-memory load frame
sdi  in  1  serial data, sampled every clk while a select is low, MSB first
pc_o  out  OPND_W  current program counter
acc_o  out  DATA_W  accumulator
state_o  out  2  FSM state (IDLE=0, LOAD=1, EXEC=2, HALT=3)
halted_o  out  1  state_o==HALT
load_done_o  out  1  one-cycle pulse when a frame is written
frame_err_o  out  1  one-cycle pulse on aborted or illegal frame

Behaviour:
- Reset (async assert, sync-released by the top): state IDLE, pc 0, acc 0, all IMEM/DMEM words 0, bit counter 0, shift register 0, pulses 0.
- IDLE:
  - run=1 → EXEC next cycle, pc←0, acc←0.
  - Else exactly one select low → LOAD. That same cycle is bit 0 of the frame.
  - Both selects low → stay IDLE, frame_err_o pulses every cycle the condition holds.
- LOAD:
  - Frame is OPND_W address bits then payload: INST_W bits for IMEM, DATA_W bits for DMEM.
  - Shift register shifts left taking sdi; counter increments.
  - On the last bit the word is written at the following edge, load_done_o pulses, state → IDLE.
  - Select rises early, or the other select falls → discard, frame_err_o pulse, → IDLE.
  - run ignored during LOAD.
- EXEC: one instruction per cycle; IMEM/DMEM read combinationally at pc / operand.
  - ISA, opnd = operand field, sext = sign-extended opnd:
    - 0 ADD acc+=D[opnd]; 1 SUB; 2 AND; 3 OR; 4 XOR.
    - 5 SHL acc<<=1; 6 SHR logical >>1.
    - 7 ST D[opnd]←acc.
    - 8 ADDI acc+=sext; 9 LI acc←sext.
    - A LD acc←D[opnd].
    - B–D NOP; E HALT.
    - F BNEZ: if acc≠0 then pc←opnd.
  - Arithmetic is modulo 2**DATA_W, no flags.
  - Otherwise pc←pc+1.
  - HALT opcode, or pc==2**OPND_W−1 executing anything but a taken BNEZ → instruction completes, state → HALT, pc holds.
  - Selects ignored in EXEC/HALT.
- HALT: acc, pc, memories frozen. run=0 → IDLE, with pc and acc retained for inspection.
- run falling in EXEC → IDLE at the next edge; the instruction in flight does not commit.

Optional Feature:
- SINGLE_STEP_EN defined: adds input step (1 bit).
  - In EXEC, an instruction commits only on the cycle after a rising edge of step (edge detector flop, reset 0); other cycles hold.
  - HALT entry is unchanged.
- Undefined: no port, one instruction per cycle.

Decomposition:
- Package acc_proc_pkg holds:
  - opcode localparams OP_ADD…OP_BNEZ;
  - state encodings ST_IDLE/ST_LOAD/ST_EXEC/ST_HALT;
  - the clog2 helper.
- One sub-module, acc_proc_loader: frame shift register, bit counter, select checking, emitting wr_imem/wr_dmem/addr/data/err.
- The core holds the FSM, datapath and memories.

Test Plan:
- Reset mid-LOAD (after 5 bits) → state 0, memories 0, no load_done_o.
- Load IMEM: {LI 3},{SUB via D[1]=1 loaded},{BNEZ 1},{HALT}; run=1 → acc 3→2→1→0, halted_o=1, pc=3, acc_o=0.
- DMEM frame with cs_d_n raised after 7 of 12 bits → frame_err_o one pulse, D unchanged, state IDLE.
- Program {LI −2 (0xE)},{ST 5},{ADDI 1},{LD 5},{HALT} → acc_o=0xFE, D[5]=0xFE.
- Straight-line NOPs to pc=15 → HALT at pc 15; run low → IDLE with pc still 15; run high → restarts from pc 0, acc 0.
- SINGLE_STEP_EN: run=1 with step held low for 20 cycles → pc stays 0; three step pulses → pc=3.
